// File: rtl/seg7_scan_scheduler.sv
// rtl/seg7_scan_scheduler.sv - 4-digit 7-segment scan scheduler with frame-aligned shadow registers
module seg7_scan_scheduler #(
    parameter  int REFRESH_DIV = 100000,
    localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] VALUE_IN,
    input  logic [3:0]  DOT_IN,
    input  logic [3:0]  DIGIT_EN_IN,
    input  logic        LOAD_IN,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        FRAME_DONE_OUT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    logic [1:0]  ptr;
    logic [15:0] act_val;
    logic [3:0]  act_dot;
    logic [3:0]  act_en;

    logic [15:0] pend_val;
    logic [3:0]  pend_dot;
    logic [3:0]  pend_en;
    logic        pend_flag;

    logic        has_higher;
    logic [1:0]  higher_idx;
    logic        boundary;
    logic        transfer;
    logic [15:0] new_val;
    logic [3:0]  new_dot;
    logic [3:0]  new_en;
    logic [1:0]  lowest_idx;
    logic [1:0]  ptr_nxt;

    assign tick = (cnt == CNT_LAST);

    // Prescaler: one tick per digit slot.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next enabled index above ptr in the currently active mask (ascending scan).
    always_comb begin
        has_higher = 1'b0;
        higher_idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(ptr)) && act_en[i]) begin
                has_higher = 1'b1;
                higher_idx = 2'(i);
            end
        end
    end

    // A frame ends on the tick where nothing enabled remains to the left of ptr.
    always_comb begin
        boundary = tick && !has_higher;
        transfer = boundary && pend_flag;
        new_val  = transfer ? pend_val : act_val;
        new_dot  = transfer ? pend_dot : act_dot;
        new_en   = transfer ? pend_en  : act_en;
    end

    // Lowest enabled index of the mask that governs the next frame.
    always_comb begin
        lowest_idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (new_en[i]) begin
                lowest_idx = 2'(i);
            end
        end
    end

    // Pointer update: restart at the boundary, advance on other ticks, else hold.
    always_comb begin
        ptr_nxt = ptr;
        if (boundary) begin
            if (new_en != 4'h0) begin
                ptr_nxt = lowest_idx;
            end
        end else if (tick) begin
            ptr_nxt = higher_idx;
        end
    end

    // Pointer and active (displayed) content; content only changes at a boundary.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ptr     <= 2'd0;
            act_val <= 16'h0000;
            act_dot <= 4'h0;
            act_en  <= 4'hF;
        end else begin
            ptr     <= ptr_nxt;
            act_val <= new_val;
            act_dot <= new_dot;
            act_en  <= new_en;
        end
    end

    // Shadow registers: a load taken on a boundary cycle survives for the next frame.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pend_val  <= 16'h0000;
            pend_dot  <= 4'h0;
            pend_en   <= 4'hF;
            pend_flag <= 1'b0;
        end else if (LOAD_IN) begin
            pend_val  <= VALUE_IN;
            pend_dot  <= DOT_IN;
            pend_en   <= DIGIT_EN_IN;
            pend_flag <= 1'b1;
        end else if (boundary) begin
            pend_flag <= 1'b0;
        end
    end

    // Registered decoder drive, computed from the post-edge pointer and content.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            SEG_SELECT_OUT <= 2'd0;
            BIN_OUT        <= 4'h0;
            DOT_OUT        <= 1'b0;
            BLANK_OUT      <= 1'b0;
            FRAME_DONE_OUT <= 1'b0;
        end else begin
            SEG_SELECT_OUT <= ptr_nxt;
            BIN_OUT        <= new_val[{ptr_nxt, 2'b00} +: 4];
            DOT_OUT        <= new_dot[ptr_nxt];
            BLANK_OUT      <= (new_en == 4'h0);
            FRAME_DONE_OUT <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb/tb_seg7_scan_scheduler.sv - scoreboard bench for seg7_scan_scheduler with a behavioural model
module tb_seg7_scan_scheduler;

    localparam int DIV = 4;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [15:0] VALUE_IN = 16'h0;
    logic [3:0]  DOT_IN = 4'h0;
    logic [3:0]  DIGIT_EN_IN = 4'hF;
    logic        LOAD_IN = 1'b0;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;
    logic        BLANK_OUT;
    logic        FRAME_DONE_OUT;

    seg7_scan_scheduler #(.REFRESH_DIV(DIV)) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .VALUE_IN(VALUE_IN),
        .DOT_IN(DOT_IN),
        .DIGIT_EN_IN(DIGIT_EN_IN),
        .LOAD_IN(LOAD_IN),
        .SEG_SELECT_OUT(SEG_SELECT_OUT),
        .BIN_OUT(BIN_OUT),
        .DOT_OUT(DOT_OUT),
        .BLANK_OUT(BLANK_OUT),
        .FRAME_DONE_OUT(FRAME_DONE_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] bin;
        logic       dot;
        logic       blank;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: a digit slot counter, a pointer, the shown and the waiting content.
    int          m_slot;
    int          m_ptr;
    logic [15:0] a_val, p_val;
    logic [3:0]  a_dot, p_dot, a_en, p_en;
    bit          p_flag;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0;
        m_ptr  = 0;
        a_val = 16'h0; a_dot = 4'h0; a_en = 4'hF;
        p_val = 16'h0; p_dot = 4'h0; p_en = 4'hF;
        p_flag = 0;
        q.delete();
    endtask

    // Model: evaluated once per clock edge from the digit-scan rules.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESETN);
            if (!RESETN) begin
                model_reset();
            end else begin
                bit   tick, bnd, more;
                exp_t e;
                tick = (m_slot == DIV - 1);
                m_slot = tick ? 0 : m_slot + 1;
                more = 0;
                for (int j = m_ptr + 1; j < 4; j++) if (a_en[j]) more = 1;
                bnd = tick && !more;
                if (bnd) begin
                    if (p_flag) begin
                        a_val = p_val; a_dot = p_dot; a_en = p_en;
                        p_flag = 0;
                    end
                    if (a_en != 4'h0) begin
                        int lo;
                        lo = -1;
                        for (int j = 0; j < 4; j++) if (a_en[j] && lo < 0) lo = j;
                        m_ptr = lo;
                    end
                end else if (tick) begin
                    int nx;
                    nx = -1;
                    for (int j = m_ptr + 1; j < 4; j++) if (a_en[j] && nx < 0) nx = j;
                    m_ptr = nx;
                end
                if (LOAD_IN) begin
                    p_val = VALUE_IN; p_dot = DOT_IN; p_en = DIGIT_EN_IN;
                    p_flag = 1;
                end
                e.sel   = 2'(m_ptr);
                e.bin   = 4'((a_val >> (4 * m_ptr)) & 16'hF);
                e.dot   = a_dot[m_ptr];
                e.blank = (a_en == 4'h0);
                e.fd    = bnd;
                q.push_back(e);
            end
        end
    end

    // Monitor: outputs are checked mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESETN) begin
                check("reset_hold", {7'b0, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_DONE_OUT}, 16'h0);
            end else if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("seg_select", {14'b0, SEG_SELECT_OUT}, {14'b0, e.sel});
                check("bin", {12'b0, BIN_OUT}, {12'b0, e.bin});
                check("dot", {15'b0, DOT_OUT}, {15'b0, e.dot});
                check("blank", {15'b0, BLANK_OUT}, {15'b0, e.blank});
                check("frame_done", {15'b0, FRAME_DONE_OUT}, {15'b0, e.fd});
            end
        end
    end

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
        @(posedge CLK); #1;
        VALUE_IN = v; DOT_IN = d; DIGIT_EN_IN = en; LOAD_IN = 1'b1;
        @(posedge CLK); #1;
        LOAD_IN = 1'b0;
        VALUE_IN = 16'($urandom); DOT_IN = 4'($urandom); DIGIT_EN_IN = 4'($urandom);
    endtask

    task automatic wait_sel(input logic [1:0] s, input string name);
        int k;
        k = 0;
        while (SEG_SELECT_OUT !== s && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for select %0d, got %0d", name, s, SEG_SELECT_OUT);
        end
    endtask

    task automatic wait_fd(input string name);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (FRAME_DONE_OUT !== 1'b1 && k < 200);
        if (k >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for frame done, got %b", name, FRAME_DONE_OUT);
        end
    endtask

    task automatic mid_reset(input string name);
        @(posedge CLK); #3;
        RESETN = 1'b0;
        #1;
        check(name, {7'b0, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_DONE_OUT}, 16'h0);
        repeat (2) @(posedge CLK);
        #3;
        RESETN = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", {7'b0, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_DONE_OUT}, 16'h0);
        #2;
        RESETN = 1'b1;
        repeat (40) @(posedge CLK);

        wait_sel(2'd1, "beef_wait");
        load(16'hBEEF, 4'b0100, 4'hF);
        repeat (40) @(posedge CLK);

        wait_fd("boundary_wait");
        repeat (15) @(posedge CLK);
        #1;
        VALUE_IN = 16'h1234; DOT_IN = 4'b0001; DIGIT_EN_IN = 4'hF; LOAD_IN = 1'b1;
        @(posedge CLK); #1;
        LOAD_IN = 1'b0;
        repeat (40) @(posedge CLK);

        load(16'hA5C3, 4'b1000, 4'b1010);
        repeat (40) @(posedge CLK);
        load(16'h5555, 4'b1111, 4'h0);
        repeat (30) @(posedge CLK);
        load(16'h9876, 4'b0100, 4'b0100);
        repeat (20) @(posedge CLK);
        load(16'h0001, 4'b0000, 4'b1000);
        repeat (20) @(posedge CLK);

        load(16'hBEEF, 4'b0000, 4'hF);
        repeat (24) @(posedge CLK);
        wait_sel(2'd2, "mid_reset_wait");
        mid_reset("async_reset");
        repeat (40) @(posedge CLK);

        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            VALUE_IN = 16'($urandom);
            DOT_IN   = 4'($urandom);
            case ($urandom_range(0, 3))
                0: DIGIT_EN_IN = 4'h0;
                1: DIGIT_EN_IN = 4'(1 << $urandom_range(0, 3));
                2: DIGIT_EN_IN = 4'hF;
                default: DIGIT_EN_IN = 4'($urandom);
            endcase
            LOAD_IN = ($urandom_range(0, 9) == 0);
            if (c == 1500) begin
                LOAD_IN = 1'b0;
                mid_reset("random_reset");
            end
        end
        @(posedge CLK); #1;
        LOAD_IN = 1'b0;
        repeat (40) @(posedge CLK);

        n_cmp++;
        if (n_cmp < 5000) begin
            n_bad++;
            $display("FAIL scoreboard_activity: compared %0d, required at least 5000", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_scheduler.md
Name: seg7_scan_scheduler

Overview:
- Time-multiplexes a 4-digit common-anode 7-segment display.
- Cycles a digit pointer at a programmable refresh rate and drives the digit-select, nibble and dot inputs of the downstream hex-to-7-segment decoder.
- Skips digits the caller has disabled.
- Applies new display content only at frame boundaries through shadow registers, so the display never tears mid-frame.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot (100 MHz gives 1 kHz per digit); legal range >= 1.
- CNT_W, $clog2(REFRESH_DIV) with a minimum of 1, prescaler counter width; derived, not overridden.

Ports:
- CLK  in  1  system clock; all logic is in this single domain.
- RESETN  in  1  reset; asynchronous, active-low.
- VALUE_IN  in  16  four hex nibbles; [3:0] = digit 0 (rightmost) … [15:12] = digit 3 (leftmost).
- DOT_IN  in  4  decimal-point request per digit; bit i = digit i, 1 = lit.
- DIGIT_EN_IN  in  4  digit enable mask; 0 = skip that digit.
- LOAD_IN  in  1  one-cycle strobe; captures VALUE_IN, DOT_IN and DIGIT_EN_IN into the pending registers.
- SEG_SELECT_OUT  out  2  current digit index, to the decoder's select input.
- BIN_OUT  out  4  nibble for the current digit, to the decoder's binary input.
- DOT_OUT  out  1  dot for the current digit (active-high; the decoder inverts it).
- BLANK_OUT  out  1  1 = no digit enabled; the board-level anode drive must be forced off.
- FRAME_DONE_OUT  out  1  one-cycle pulse on each frame-boundary tick.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - prescaler = 0, ptr = 0.
  - Active value = 16'h0000, active dot = 4'h0, active enable = 4'hF.
  - Pending registers equal the active reset values; pending flag = 0.
  - Outputs: SEG_SELECT_OUT = 0, BIN_OUT = 0, DOT_OUT = 0, BLANK_OUT = 0, FRAME_DONE_OUT = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (count == REFRESH_DIV-1).
  - REFRESH_DIV = 1 gives a tick every cycle.
- Pending capture:
  - LOAD_IN = 1 loads all three pending registers and sets the pending flag.
  - Back-to-back loads: the last one wins.
- Frame boundary:
  - A tick where the old active enable mask has no enabled index above ptr.
  - This includes the case of a single enabled digit, and every tick while the mask is 4'h0.
- On a frame-boundary tick:
  - FRAME_DONE_OUT = 1 for exactly that one cycle (asserted on the following edge, lasting one cycle).
  - If the pending flag is set, pending contents as held before this edge are copied to active, and the flag is cleared.
  - A LOAD_IN in the same cycle updates pending and keeps the flag set; its data transfers at the next boundary.
  - ptr is set to the lowest enabled index of the (possibly new) active mask.
  - If that mask is 4'h0, ptr holds its value.
- On a non-boundary tick: ptr advances to the next higher enabled index of the active mask; scan order is ascending.
- Outputs: registered and updated on the same edge as ptr/active.
  - SEG_SELECT_OUT = ptr.
  - BIN_OUT = active value[4*ptr+3 : 4*ptr].
  - DOT_OUT = active dot[ptr].
  - BLANK_OUT = (active enable == 4'h0).
  - BIN_OUT and DOT_OUT also refresh on a boundary transfer even if ptr is unchanged.
- Between ticks: all outputs are stable and do not change on LOAD_IN.

Test Plan:
- REFRESH_DIV=4, reset released, no loads -> SEG_SELECT_OUT goes 0,1,2,3,0 with 4 cycles per digit; BIN_OUT = 0; FRAME_DONE_OUT pulses once every 16 cycles, on the 3→0 tick.
- LOAD_IN with VALUE_IN = 16'hBEEF, DOT_IN = 4'b0100 while ptr = 1 -> digits 2 and 3 still show 0; after the next boundary the frame shows F, E, E (DOT_OUT = 1), B.
- Load DIGIT_EN_IN = 4'b1010 -> after the boundary the scan is 1,3,1,3; FRAME_DONE_OUT pulses every 8 cycles; digits 0 and 2 are never selected.
- Load DIGIT_EN_IN = 4'h0 -> after the boundary BLANK_OUT = 1, ptr frozen, FRAME_DONE_OUT pulses every 4 cycles; load 4'b0100 -> next tick gives SEG_SELECT_OUT = 2 and BLANK_OUT = 0.
- LOAD_IN asserted on a boundary-tick cycle with value 16'h1234 -> not shown in the frame that follows; shown after the next boundary.
- RESETN pulled low mid-scan (ptr = 2, active value 16'hBEEF) -> outputs go to reset values immediately without waiting for a CLK edge; after release the scan restarts at 0 showing 0000.
